// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Keymap entries are indexed by {row, col}; entry 0 sits in the least significant nibble.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Rows 0..3, columns 0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous, active-low bus.
// Reset value is all-ones, which is the idle level of the bus.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces press and release,
// and reports one key_valid pulse per accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DB_COUNT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DB_COUNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_reg;
  logic             sample_tick;

  state_t     state_reg, state_next;
  logic [1:0] col_idx_reg, col_idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0] row_pat_reg, row_pat_next;
  logic [1:0] row_idx_reg, row_idx_next;
  logic [3:0] key_code_reg, key_code_next;
  logic       key_valid_reg, key_valid_next;
  logic       key_held_reg, key_held_next;

  logic       single_low;
  logic [1:0] single_idx;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (row_sync)
  );

  // Free-running dwell counter; its last cycle is the sampling instant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  assign sample_tick = (div_reg == DIV_LAST);

  always_comb begin
    single_low = 1'b1;
    single_idx = 2'd0;
    case (row_sync)
      4'b1110: single_idx = 2'd0;
      4'b1101: single_idx = 2'd1;
      4'b1011: single_idx = 2'd2;
      4'b0111: single_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_SCAN;
      col_idx_reg   <= 2'd0;
      cnt_reg       <= '0;
      row_pat_reg   <= 4'hF;
      row_idx_reg   <= 2'd0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      cnt_reg       <= cnt_next;
      row_pat_reg   <= row_pat_next;
      row_idx_reg   <= row_idx_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  // All decisions are taken only at sample instants; the column stays frozen outside SCAN.
  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    cnt_next       = cnt_reg;
    row_pat_next   = row_pat_reg;
    row_idx_next   = row_idx_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    if (sample_tick) begin
      case (state_reg)
        ST_SCAN: begin
          if (single_low) begin
            row_pat_next = row_sync;
            row_idx_next = single_idx;
            cnt_next     = '0;
            state_next   = ST_DEBOUNCE;
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_sync == row_pat_reg) begin
            if (cnt_reg == CNT_LAST) begin
              key_code_next  = key_lookup(row_idx_reg, col_idx_reg);
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              cnt_next       = '0;
              state_next     = ST_HELD;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end else begin
            cnt_next     = '0;
            col_idx_next = col_idx_reg + 2'd1;
            state_next   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (row_sync == 4'hF) begin
            if (cnt_reg == CNT_LAST) begin
              key_held_next = 1'b0;
              cnt_next      = '0;
              col_idx_next  = col_idx_reg + 2'd1;
              state_next    = ST_SCAN;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end
        default: begin
          cnt_next   = '0;
          state_next = ST_SCAN;
        end
      endcase
    end
  end

  assign col_n     = ~(4'b0001 << col_idx_reg);
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DB_COUNT=3 and a behavioural keypad.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       key_active = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [1:0] key_col = 2'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'hF;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int valid_cnt = 0;
  int held_falls = 0;
  logic held_d = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DB_COUNT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row low only while its column is driven.
  always_comb begin
    row_n = 4'hF;
    if (force_en) row_n = force_val;
    else if (key_active && !col_n[key_col]) row_n = ~(4'b0001 << key_row);
  end

  always @(posedge clk) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
    held_d <= key_held;
    if (held_d && !key_held) held_falls <= held_falls + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_release(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!key_held) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Returns at the first negedge after col_n switches to target.
  task automatic wait_col(input logic [3:0] target, input string tag);
    logic found;
    logic [3:0] prev;
    found = 1'b0;
    prev = col_n;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col_n == target && prev != target) begin
        found = 1'b1;
        break;
      end
      prev = col_n;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v_base;
    int f_base;
    int first_low;
    int valid_at;
    logic found;
    logic [1:0] t_row [5];
    logic [1:0] t_col [5];
    logic [3:0] t_exp [5];
    t_row = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd3};
    t_col = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd1};
    t_exp = '{4'h1, 4'hA, 4'hC, 4'hE, 4'h0};

    // Reset state and first column step
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col_n), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("col0_dwell", 32'(col_n), 32'hE);
    @(negedge clk);
    check("col1_after4", 32'(col_n), 32'hD);

    // Key 5 held 200 cycles
    v_base = valid_cnt;
    f_base = held_falls;
    key_row = 2'd1; key_col = 2'd1; key_active = 1'b1;
    first_low = -1; valid_at = 0; found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (first_low < 0 && row_n != 4'hF) first_low = n;
      if (key_valid) begin
        valid_at = n;
        found = 1'b1;
        break;
      end
    end
    check("k5_accept", 32'(found), 32'd1);
    check("k5_latency_ok", 32'((valid_at - first_low) <= 19), 32'd1);
    repeat (190) @(negedge clk);
    check("k5_one_pulse", 32'(valid_cnt - v_base), 32'd1);
    check("k5_code", 32'(key_code), 32'h5);
    check("k5_held", 32'(key_held), 32'd1);
    check("k5_held_steady", 32'(held_falls - f_base), 32'd0);
    key_active = 1'b0;
    wait_release("k5_release");
    check("k5_next_col", 32'(col_n), 32'hB);
    check("k5_no_repeat", 32'(valid_cnt - v_base), 32'd1);

    // Short press: detect + one match, then release
    v_base = valid_cnt;
    wait_col(4'b1101, "short_find_col1");
    key_active = 1'b1;
    repeat (8) @(negedge clk);
    key_active = 1'b0;
    repeat (40) @(negedge clk);
    check("short_no_valid", 32'(valid_cnt - v_base), 32'd0);
    check("short_code_kept", 32'(key_code), 32'h5);
    check("short_not_held", 32'(key_held), 32'd0);
    wait_col(4'b1110, "short_rotates");

    // Release with a low glitch after two high samples
    v_base = valid_cnt;
    key_active = 1'b1;
    wait_valid("glitch_accept");
    force_val = 4'hF; force_en = 1'b1; key_active = 1'b0;
    repeat (8) @(negedge clk);
    force_val = 4'b1101;
    repeat (4) @(negedge clk);
    check("glitch_held_a", 32'(key_held), 32'd1);
    force_val = 4'hF;
    repeat (8) @(negedge clk);
    check("glitch_held_b", 32'(key_held), 32'd1);
    repeat (4) @(negedge clk);
    check("glitch_dropped", 32'(key_held), 32'd0);
    check("glitch_next_col", 32'(col_n), 32'hB);
    check("glitch_one_pulse", 32'(valid_cnt - v_base), 32'd1);
    force_en = 1'b0;

    // Two rows low is ignored
    v_base = valid_cnt;
    force_val = 4'b1100; force_en = 1'b1;
    wait_col(4'b1110, "dbl_find_col0");
    repeat (4) @(negedge clk);
    check("dbl_rotates", 32'(col_n), 32'hD);
    repeat (12) @(negedge clk);
    check("dbl_no_valid", 32'(valid_cnt - v_base), 32'd0);
    check("dbl_not_held", 32'(key_held), 32'd0);
    force_en = 1'b0;

    // row3/col2 -> F
    key_row = 2'd3; key_col = 2'd2; key_active = 1'b1;
    wait_valid("kF_accept");
    check("kF_code", 32'(key_code), 32'hF);
    key_active = 1'b0;
    wait_release("kF_release");

    // Keymap corners
    for (int t = 0; t < 5; t++) begin
      key_row = t_row[t]; key_col = t_col[t]; key_active = 1'b1;
      wait_valid("map_accept");
      check($sformatf("map_r%0d_c%0d", t_row[t], t_col[t]), 32'(key_code), 32'(t_exp[t]));
      key_active = 1'b0;
      wait_release("map_release");
    end

    // Reset during DEBOUNCE
    v_base = valid_cnt;
    key_row = 2'd1; key_col = 2'd1;
    wait_col(4'b1101, "dbrst_find_col1");
    key_active = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    key_active = 1'b0;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("dbrst_no_valid", 32'(valid_cnt - v_base), 32'd0);

    // Reset during HELD
    key_active = 1'b1;
    wait_valid("hrst_accept");
    repeat (4) @(negedge clk);
    v_base = valid_cnt;
    reset = 1'b0;
    #1;
    check("hrst_held", 32'(key_held), 32'd0);
    check("hrst_code", 32'(key_code), 32'h0);
    check("hrst_valid", 32'(key_valid), 32'd0);
    check("hrst_col", 32'(col_n), 32'hE);
    repeat (3) @(negedge clk);
    key_active = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("hrst_col_restart", 32'(col_n), 32'hE);
    check("hrst_no_valid", 32'(valid_cnt - v_base), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per column dwell and per debounce sample (legal range >= 4).
REQ-002 SHALL have parameter DB_COUNT, default 10, consecutive matching samples needed to accept a press or a release (legal range >= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code  output  4  hex code of last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when key_code updates.
REQ-009 SHALL have port key_held  output  1  level, high from acceptance until debounced release.

Function
REQ-010 SHALL pass row_n through a 2-flop synchronizer before any use; "sample" means the synchronized value on the last cycle of a SCAN_DIV dwell.
REQ-011 SHALL implement states SCAN, DEBOUNCE, HELD.
REQ-012 In SCAN, col_n SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after each SCAN_DIV cycles.
REQ-013 In SCAN, a sample with exactly one row low SHALL latch column index and row pattern, freeze col_n, and enter DEBOUNCE; all-high or two-or-more-low samples SHALL be ignored and rotation continues.
REQ-014 In DEBOUNCE, each sample equal to the latched pattern SHALL increment a match counter; any mismatching sample SHALL clear it, unfreeze col_n and return to SCAN with no output change.
REQ-015 On the DB_COUNT-th consecutive match, the block SHALL update key_code, pulse key_valid for exactly one cycle, coincidentally raise key_held, and enter HELD.
REQ-016 key_code mapping SHALL be: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E(*),0,F(#),D, for columns 0..3.
REQ-017 In HELD, col_n SHALL remain frozen; DB_COUNT consecutive all-high samples SHALL drop key_held and return to SCAN with col_n advancing to the next column; any low sample SHALL clear the release counter.
REQ-018 A key held indefinitely SHALL produce exactly one key_valid pulse; no auto-repeat.
REQ-019 Presses on other keys while in HELD SHALL be ignored; key_code SHALL hold its value between acceptances.
REQ-020 Press latency from stable row_n low (while its column is driven) to key_valid SHALL not exceed (DB_COUNT+1)*SCAN_DIV+3 cycles.

Reset
REQ-021 While reset is low, the block SHALL asynchronously force state SCAN, col_n=1110, key_code=0, key_valid=0, key_held=0, all counters and synchronizer flops cleared.
REQ-022 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort with no key_valid pulse; after release, scanning restarts from column 0.

Structure
REQ-023 A shared package keypad_pkg SHALL hold the state enumeration and the 16-entry keymap constant.
REQ-024 The row synchronizer SHALL be a sub-module sync_2ff (width parameter, async active-low reset to all-ones).

Verification (SCAN_DIV=4, DB_COUNT=3)
REQ-025 Reset low then high -> col_n=1110, key_code=0, key_valid=0, key_held=0; col_n=1101 after 4 cycles.
REQ-026 row_n=1101 whenever col_n=1101, held 200 cycles -> exactly one key_valid, key_code=5, key_held=1 throughout.
REQ-027 Key 5 pressed for 2 sample periods then released -> no key_valid, key_code unchanged, return to SCAN.
REQ-028 After acceptance, release with one low glitch sample after 2 high samples -> key_held stays 1 until 3 further consecutive high samples.
REQ-029 row_n=1100 in column 0 -> ignored, no pulse, rotation continues; row_n=0111 in column 2 -> key_code=F.
REQ-030 Reset pulsed during HELD -> outputs return to reset values immediately, no key_valid.
